// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore main controller for the multicycle MIPS-style core.
// It sequences fetch, decode, execute and writeback.
// It handles memory wait states in FETCH, MEMRD and MEMWR.
// It has an optional BNE mode and a sticky illegal-opcode trap.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   op         opcode from the instruction register
//   mem_ready  memory completes the current access this cycle
//   pcwrite, irwrite, regwrite, memwrite, branch, branch_ne   datapath strobes
//   iord, alusrca, regdst, memtoreg                            mux selects
//   alusrcb    00 reg B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc      00 ALU result, 01 ALUOut, 10 jump target
//   aluop      00 add, 01 sub, 10 funct-decoded
//   illegal    sticky trap flag
//   state_o    current state (debug)
module multicycle_ctrl #(
    parameter int unsigned            OP_W     = 3,
    parameter logic [OP_W-1:0]        OP_RTYPE = OP_W'(0),
    parameter logic [OP_W-1:0]        OP_LW    = OP_W'(1),
    parameter logic [OP_W-1:0]        OP_SW    = OP_W'(2),
    parameter logic [OP_W-1:0]        OP_BEQ   = OP_W'(3),
    parameter logic [OP_W-1:0]        OP_ADDI  = OP_W'(4),
    parameter logic [OP_W-1:0]        OP_J     = OP_W'(5),
    parameter logic [OP_W-1:0]        OP_BNE   = OP_W'(6),
    parameter bit                     EN_BNE   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pcwrite,
    output logic            irwrite,
    output logic            regwrite,
    output logic            memwrite,
    output logic            branch,
    output logic            branch_ne,
    output logic            iord,
    output logic            alusrca,
    output logic            regdst,
    output logic            memtoreg,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [1:0]      aluop,
    output logic            illegal,
    output logic [3:0]      state_o
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] ADDIEX = 4'd9;
    localparam logic [3:0] ADDIWB = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] TRAP   = 4'd15;

    logic [3:0] state_q, state_d;
    logic       illegal_q;
    logic [3:0] out_state;
    logic       is_bne;

    // BNE is only recognised when the mode is enabled; otherwise it traps.
    assign is_bne = EN_BNE && (op == OP_BNE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW)       state_d = MEMADR;
                else if (op == OP_RTYPE)              state_d = EXEC;
                else if (op == OP_BEQ || is_bne)      state_d = BRANCH;
                else if (op == OP_ADDI)               state_d = ADDIEX;
                else if (op == OP_J)                  state_d = JUMP;
                else                                  state_d = TRAP;
            end
            // op is still held by the IR, so it selects load vs store here.
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            // TRAP is only left by reset, so this stays set once taken.
            illegal_q <= (state_d == TRAP);
        end
    end

    // During reset the selects show FETCH values and every strobe is held low.
    assign out_state = reset ? FETCH : state_q;

    always_comb begin
        pcwrite   = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        iord      = 1'b0;
        alusrca   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        case (out_state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch    = (op == OP_BEQ);
                branch_ne = is_bne;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcwrite   = 1'b0;
            irwrite   = 1'b0;
            regwrite  = 1'b0;
            memwrite  = 1'b0;
            branch    = 1'b0;
            branch_ne = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven directed check of multicycle_ctrl.
// A second instance with EN_BNE=0 checks that BNE traps.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, mem_ready;
    logic [2:0] op;
    logic       pcwrite, irwrite, regwrite, memwrite, branch, branch_ne;
    logic       iord, alusrca, regdst, memtoreg, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state_o;

    logic       reset2, mem_ready2;
    logic [2:0] op2;
    logic       pcwrite2, irwrite2, regwrite2, memwrite2, branch2, branch_ne2;
    logic       iord2, alusrca2, regdst2, memtoreg2, illegal2;
    logic [1:0] alusrcb2, pcsrc2, aluop2;
    logic [3:0] state2;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .branch(branch), .branch_ne(branch_ne), .iord(iord), .alusrca(alusrca),
        .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .illegal(illegal), .state_o(state_o)
    );

    multicycle_ctrl #(.EN_BNE(1'b0)) dut_nobne (
        .clk(clk), .reset(reset2), .op(op2), .mem_ready(mem_ready2),
        .pcwrite(pcwrite2), .irwrite(irwrite2), .regwrite(regwrite2),
        .memwrite(memwrite2), .branch(branch2), .branch_ne(branch_ne2), .iord(iord2),
        .alusrca(alusrca2), .regdst(regdst2), .memtoreg(memtoreg2), .alusrcb(alusrcb2),
        .pcsrc(pcsrc2), .aluop(aluop2), .illegal(illegal2), .state_o(state2)
    );

    // {pcwrite irwrite regwrite memwrite branch branch_ne iord alusrca regdst memtoreg
    //  alusrcb pcsrc aluop illegal}
    logic [16:0] outs;
    assign outs = {pcwrite, irwrite, regwrite, memwrite, branch, branch_ne, iord, alusrca,
                   regdst, memtoreg, alusrcb, pcsrc, aluop, illegal};

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [16:0] mk(
        input logic pcw, input logic irw, input logic rw, input logic mw,
        input logic br, input logic bne, input logic io, input logic asa,
        input logic rd, input logic m2r, input logic [1:0] asb, input logic [1:0] pcs,
        input logic [1:0] aop, input logic ill);
        return {pcw, irw, rw, mw, br, bne, io, asa, rd, m2r, asb, pcs, aop, ill};
    endfunction

    task automatic add(input logic r, input logic [2:0] o, input logic rdy,
                       input logic [3:0] s, input logic [16:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = rdy; v.st = s; v.exp = e;
        tbl.push_back(v);
    endtask

    logic [16:0] e_fr, e_fw, e_dec, e_ma, e_mrd, e_mwb, e_mwr, e_ex, e_awb;
    logic [16:0] e_beq, e_bne, e_aix, e_aiw, e_j, e_trap, e_rstt;

    initial begin
        int n;
        reset = 1'b1; op = 3'd0; mem_ready = 1'b0;
        reset2 = 1'b1; op2 = 3'd0; mem_ready2 = 1'b0;

        e_fr   = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
        e_fw   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
        e_dec  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0);
        e_ma   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0);
        e_mrd  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
        e_mwb  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0);
        e_mwr  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
        e_ex   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0);
        e_awb  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
        e_beq  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0);
        e_bne  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0);
        e_aix  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0);
        e_aiw  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
        e_j    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0);
        e_trap = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1);
        e_rstt = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1);

        // reset state, strobes low and FETCH selects while reset is high
        add(1'b1, 3'd0, 1'b1, 4'd0, e_fw);
        // R-type: 0,1,6,7
        add(1'b0, 3'd0, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd0, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd0, 1'b1, 4'd6, e_ex);
        add(1'b0, 3'd0, 1'b1, 4'd7, e_awb);
        // LW with 3 wait cycles in MEMRD: 8 cycles
        add(1'b0, 3'd1, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd1, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd1, 1'b1, 4'd2, e_ma);
        add(1'b0, 3'd1, 1'b0, 4'd3, e_mrd);
        add(1'b0, 3'd1, 1'b0, 4'd3, e_mrd);
        add(1'b0, 3'd1, 1'b0, 4'd3, e_mrd);
        add(1'b0, 3'd1, 1'b1, 4'd3, e_mrd);
        add(1'b0, 3'd1, 1'b1, 4'd4, e_mwb);
        // SW with one fetch wait and 2 wait cycles in MEMWR: memwrite for 3 cycles
        add(1'b0, 3'd2, 1'b0, 4'd0, e_fw);
        add(1'b0, 3'd2, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd2, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd2, 1'b1, 4'd2, e_ma);
        add(1'b0, 3'd2, 1'b0, 4'd5, e_mwr);
        add(1'b0, 3'd2, 1'b0, 4'd5, e_mwr);
        add(1'b0, 3'd2, 1'b1, 4'd5, e_mwr);
        // BEQ (mem_ready ignored in DECODE) then BNE
        add(1'b0, 3'd3, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd3, 1'b0, 4'd1, e_dec);
        add(1'b0, 3'd3, 1'b1, 4'd8, e_beq);
        add(1'b0, 3'd6, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd6, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd6, 1'b0, 4'd8, e_bne);
        // ADDI then J
        add(1'b0, 3'd4, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd4, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd4, 1'b0, 4'd9, e_aix);
        add(1'b0, 3'd4, 1'b1, 4'd10, e_aiw);
        add(1'b0, 3'd5, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd5, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd5, 1'b0, 4'd11, e_j);
        // illegal op 7: TRAP held 10 cycles regardless of op/mem_ready, then reset
        add(1'b0, 3'd7, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd7, 1'b1, 4'd1, e_dec);
        for (int i = 0; i < 10; i++) begin
            add(1'b0, 3'(i), 1'(i), 4'd15, e_trap);
        end
        add(1'b1, 3'd0, 1'b1, 4'd15, e_rstt);
        add(1'b0, 3'd0, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd0, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd0, 1'b1, 4'd6, e_ex);
        add(1'b0, 3'd0, 1'b1, 4'd7, e_awb);
        // reset asserted in MEMWR drops memwrite in the same cycle
        add(1'b0, 3'd2, 1'b1, 4'd0, e_fr);
        add(1'b0, 3'd2, 1'b1, 4'd1, e_dec);
        add(1'b0, 3'd2, 1'b1, 4'd2, e_ma);
        add(1'b0, 3'd2, 1'b0, 4'd5, e_mwr);
        add(1'b1, 3'd2, 1'b0, 4'd5, e_fw);
        add(1'b0, 3'd2, 1'b0, 4'd0, e_fw);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            op = tbl[i].op;
            mem_ready = tbl[i].rdy;
            #1;
            checks++;
            if (state_o !== tbl[i].st) begin
                failures++;
                $display("FAIL vec%0d state: got %0d want %0d", i, state_o, tbl[i].st);
            end
            checks++;
            if (outs !== tbl[i].exp) begin
                failures++;
                $display("FAIL vec%0d outs: got %b want %b", i, outs, tbl[i].exp);
            end
            @(posedge clk);
            #1;
        end

        // EN_BNE=0: BNE must trap two edges after leaving reset
        reset2 = 1'b0; op2 = 3'd6; mem_ready2 = 1'b1;
        n = 0;
        while (state2 != 4'd15 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (state2 !== 4'd15) begin
            failures++;
            $display("FAIL nobne_trap: state got %0d want 15 (timeout)", state2);
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL nobne_latency: got %0d edges want 2", n);
        end
        checks++;
        if (illegal2 !== 1'b1 || branch_ne2 !== 1'b0) begin
            failures++;
            $display("FAIL nobne_flags: illegal=%b branch_ne=%b want 1 0", illegal2, branch_ne2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
